// File: rtl/ratio_divider.sv
// Sequential unsigned divider: 32-bit dividend by 8-bit divisor using one restoring
// shift-subtract step per clock, with divide-by-zero detected up front.
module ratio_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] dvd_q;
  logic [7:0]  dvs_q;
  logic [8:0]  part_rem;
  logic [4:0]  count;

  logic [8:0]  trial;
  logic [8:0]  diff;
  logic        fits;
  logic [8:0]  next_rem;

  // The partial remainder is always below the divisor, so after shifting in the
  // next dividend bit it still fits in 9 bits and the compare cannot overflow.
  always_comb begin
    trial    = (part_rem << 1) | {8'b0, dvd_q[31]};
    fits     = (trial >= {1'b0, dvs_q});
    diff     = trial - {1'b0, dvs_q};
    next_rem = fits ? diff : trial;
  end

  // The dividend register doubles as the quotient shift register: each step
  // shifts out one dividend bit at the top and shifts in one quotient bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_rem    <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            part_rem <= '0;
            if (divisor == 8'd0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= 32'hFFFF_FFFF;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              count <= 5'd31;
            end
          end
        end
        RUN: begin
          dvd_q    <= {dvd_q[30:0], fits};
          part_rem <= next_rem;
          count    <= count - 5'd1;
          if (count == 5'd0) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= {dvd_q[30:0], fits};
            remainder   <= next_rem[7:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ratio_divider.sv
// Directed bench for ratio_divider: expected results are queued when a request is
// driven and compared when the divider pulses done.
module tb_ratio_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [7:0]  r;
    logic        dbz;
  } result_t;

  result_t expected_q[$];
  int      checks = 0;
  int      errors = 0;

  ratio_divider dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push_expected(input logic [31:0] a, input logic [7:0] b);
    result_t e;
    if (b == 8'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = a[7:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = a / {24'd0, b};
      e.r   = 8'(a % {24'd0, b});
      e.dbz = 1'b0;
    end
    expected_q.push_back(e);
  endtask

  // Drives one start pulse, then measures cycles to done and cycles with busy high.
  task automatic apply_stimulus(input logic [31:0] a, input logic [7:0] b, input bit push,
                                output int lat, output int busy_cycles);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) push_expected(a, b);
    @(posedge clk);
    #1 start = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued request.
  always @(negedge clk) begin
    if (done) begin
      result_t e;
      check_output("busy_with_done", {31'd0, busy}, 32'd0);
      if (expected_q.size() == 0) begin
        check_output("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = expected_q.pop_front();
        check_output("quotient", quotient, e.q);
        check_output("remainder", {24'd0, remainder}, {24'd0, e.r});
        check_output("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  initial begin
    int lat;
    int bcyc;
    int pulses;
    int t1, t2, t3;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    check_output("reset_quotient", quotient, 32'd0);
    check_output("reset_remainder", {24'd0, remainder}, 32'd0);
    check_output("reset_dbz", {31'd0, div_by_zero}, 32'd0);

    $display("[TB] 600 / 11");
    apply_stimulus(32'd600, 8'd11, 1'b1, lat, bcyc);
    check_output("latency_600_11", lat, 33);
    check_output("busy_cycles_600_11", bcyc, 32);

    $display("[TB] max dividend / 1");
    apply_stimulus(32'hFFFF_FFFF, 8'd1, 1'b1, lat, bcyc);
    check_output("latency_max_1", lat, 33);

    $display("[TB] divide by zero");
    apply_stimulus(32'h0000_1234, 8'd0, 1'b1, lat, bcyc);
    check_output("latency_dbz", lat, 1);
    check_output("busy_cycles_dbz", bcyc, 0);

    $display("[TB] 100 / 7 with start re-pulsed mid-run");
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    push_expected(32'd100, 8'd7);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 10) begin
        dividend = 32'd200;
        divisor  = 8'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check_output("latency_repulse", lat, 33);
    repeat (5) @(negedge clk);
    check_output("hold_quotient", quotient, 32'd14);
    check_output("hold_remainder", {24'd0, remainder}, 32'd2);

    $display("[TB] reset during RUN");
    @(negedge clk);
    dividend = 32'd600;
    divisor  = 8'd11;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort_done", {31'd0, done}, 32'd0);
    check_output("abort_quotient", quotient, 32'd0);
    check_output("abort_remainder", {24'd0, remainder}, 32'd0);
    check_output("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_output("abort_no_done", pulses, 0);
    apply_stimulus(32'd600, 8'd11, 1'b1, lat, bcyc);
    check_output("latency_after_abort", lat, 33);

    $display("[TB] reset wins over start");
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1 begin
      reset = 1'b0;
      start = 1'b0;
    end
    @(negedge clk);
    check_output("reset_priority_busy", {31'd0, busy}, 32'd0);

    $display("[TB] 5 / 255");
    apply_stimulus(32'd5, 8'd255, 1'b1, lat, bcyc);
    check_output("latency_5_255", lat, 33);

    $display("[TB] start held high");
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 8'd13;
    start    = 1'b1;
    for (int k = 0; k < 3; k++) push_expected(32'd1000, 8'd13);
    pulses = 0;
    t1 = 0;
    t2 = 0;
    t3 = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (pulses == 1) t1 = i;
        if (pulses == 2) t2 = i;
        if (pulses == 3) begin
          t3 = i;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check_output("held_first_latency", t1, 33);
    check_output("held_period_1", t2 - t1, 34);
    check_output("held_period_2", t3 - t2, 34);

    repeat (40) @(negedge clk);
    check_output("queue_drained", expected_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ratio_divider.md
RATIO_DIVIDER -- requirements
Module: ratio_divider

Interface
REQ-001 SHALL declare clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL declare reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL declare start  input  1  request to begin a division; sampled only in IDLE.
REQ-004 SHALL declare dividend  input  32  unsigned numerator, e.g. n*factorial(n); captured when start is accepted.
REQ-005 SHALL declare divisor  input  8  unsigned denominator, e.g. 2n+1; captured when start is accepted.
REQ-006 SHALL declare busy  output  1  high while a division is in progress (RUN state).
REQ-007 SHALL declare done  output  1  one-cycle pulse marking valid results.
REQ-008 SHALL declare quotient  output  32  unsigned quotient.
REQ-009 SHALL declare remainder  output  8  unsigned remainder.
REQ-010 SHALL declare div_by_zero  output  1  high when the captured divisor was 0.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with start=1 and divisor!=0, capture the operands, clear the partial remainder, load a 5-bit iteration counter with 31, and enter RUN on the same edge.
REQ-013 SHALL, in IDLE with start=1 and divisor==0, skip RUN and enter DONE on the same edge.
REQ-014 SHALL, in RUN, perform one restoring shift-subtract step per cycle, MSB of the dividend first, producing one quotient bit per cycle.
REQ-015 SHALL use a 9-bit partial remainder so that the compare against the 8-bit divisor never overflows.
REQ-016 SHALL remain in RUN for exactly 32 cycles; on the edge where the counter equals 0, it SHALL enter DONE.
REQ-017 SHALL update quotient and remainder on the edge entering DONE.
REQ-018 SHALL assert done for exactly one cycle, in DONE, then return to IDLE unconditionally.
REQ-019 SHALL produce done in the 33rd cycle after the edge that accepted start.
REQ-020 SHALL, for a zero divisor, produce quotient=32'hFFFF_FFFF, remainder=dividend[7:0] and div_by_zero=1, with done in the cycle after acceptance.
REQ-021 SHALL clear div_by_zero when any non-zero-divisor division completes.
REQ-022 SHALL hold quotient, remainder and div_by_zero stable between done pulses.
REQ-023 SHALL ignore start while in RUN or DONE, with no queueing.
REQ-024 SHALL allow start to be accepted in the IDLE cycle immediately following DONE, giving back-to-back throughput of 34 cycles per operation.
REQ-025 SHALL assert busy only in RUN; busy and done SHALL never be high together.
REQ-026 SHALL be register-based only: no combinational divide operator and no multi-cycle path.

Reset
REQ-027 SHALL, while reset=1 at a rising edge, enter IDLE and clear busy, done, quotient, remainder, div_by_zero, the counter and the internal operand registers.
REQ-028 SHALL, on reset during RUN or DONE, abandon the operation: no done pulse, and outputs at 0 on the following cycle.
REQ-029 SHALL give reset priority over start when both are high at the same edge.

Verification
REQ-030 SHALL cover: dividend=600, divisor=11, start for 1 cycle -> busy for 32 cycles, then done with quotient=54, remainder=6, div_by_zero=0.
REQ-031 SHALL cover: dividend=32'hFFFF_FFFF, divisor=1 -> quotient=32'hFFFF_FFFF, remainder=0.
REQ-032 SHALL cover: dividend=32'h0000_1234, divisor=0 -> done one cycle after start, quotient=32'hFFFF_FFFF, remainder=8'h34, div_by_zero=1.
REQ-033 SHALL cover: start=1 with dividend=100, divisor=7, then start re-pulsed at cycle 10 with different operands -> second request ignored, result quotient=14, remainder=2.
REQ-034 SHALL cover: reset asserted at cycle 15 of RUN -> busy=0 and all outputs 0 next cycle, no done pulse, and a subsequent 600/11 completes correctly.
REQ-035 SHALL cover: dividend=5, divisor=255 -> quotient=0, remainder=5; then start held high continuously -> a done pulse every 34 cycles.
